pll_rst_seq: RTL and testbench

//  Sequences the iCE40 SB_PLL40 in the oscillator block and the system reset derived from it.

---
 rtl/pll_rst_seq_if.sv | 36 +++
 rtl/pll_rst_seq.sv | 118 +++++++++++
 tb/tb_pll_rst_seq.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/pll_rst_seq_if.sv
// PLL/reset sequencer signal bundle.
// master drives the PLL status and requests; slave is the sequencer.
interface pll_rst_seq_if #(
  parameter int CNT_W = 8
) ();
  logic             pll_lock;
  logic             relock_req;
  logic             pll_resetb;
  logic             sys_rst;
  logic             ready;
  logic [1:0]       state;
  logic [CNT_W-1:0] fail_cnt;
  logic [CNT_W-1:0] lost_cnt;

  modport master (
    output pll_lock,
    output relock_req,
    input  pll_resetb,
    input  sys_rst,
    input  ready,
    input  state,
    input  fail_cnt,
    input  lost_cnt
  );

  modport slave (
    input  pll_lock,
    input  relock_req,
    output pll_resetb,
    output sys_rst,
    output ready,
    output state,
    output fail_cnt,
    output lost_cnt
  );
endinterface

// File: rtl/pll_rst_seq.sv
// SB_PLL40 reset/lock sequencer on the crystal clock.
// Releases sys_rst only after a lock has held for STABLE_CYCLES.
module pll_rst_seq #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 4096,
  parameter int STABLE_CYCLES  = 256,
  parameter int CNT_W          = 8
) (
  input logic         clk,
  input logic         rst,
  pll_rst_seq_if.slave bus
);

  typedef enum logic [1:0] {
    PLL_RST   = 2'b00,
    WAIT_LOCK = 2'b01,
    STABLE    = 2'b10,
    RUN       = 2'b11
  } state_t;

  localparam int M1   = (PLL_RST_CYCLES > LOCK_TIMEOUT)
                      ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAXC = (M1 > STABLE_CYCLES) ? M1 : STABLE_CYCLES;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [TW-1:0] RST_END  = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] WAIT_END = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STAB_END = TW'(STABLE_CYCLES - 1);

  state_t           cur;
  state_t           nxt;
  logic [TW-1:0]    timer;
  logic             sync1;
  logic             lock_s;
  logic             inc_fail;
  logic             inc_lost;
  logic             resetb_q;
  logic             sys_rst_q;
  logic             ready_q;
  logic [CNT_W-1:0] fail_q;
  logic [CNT_W-1:0] lost_q;

  // Bring the asynchronous PLL lock into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= bus.pll_lock;
      lock_s <= sync1;
    end
  end

  // Next-state decision; a relock request overrides everything.
  always_comb begin
    nxt      = cur;
    inc_fail = 1'b0;
    inc_lost = 1'b0;
    if (bus.relock_req) begin
      nxt = PLL_RST;
    end else begin
      unique case (cur)
        PLL_RST: begin
          if (timer == RST_END) nxt = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            nxt = STABLE;
          end else if (timer == WAIT_END) begin
            nxt      = PLL_RST;
            inc_fail = 1'b1;
          end
        end
        STABLE: begin
          if (!lock_s) nxt = WAIT_LOCK;
          else if (timer == STAB_END) nxt = RUN;
        end
        RUN: begin
          if (!lock_s) begin
            nxt      = PLL_RST;
            inc_lost = 1'b1;
          end
        end
        default: nxt = PLL_RST;
      endcase
    end
  end

  // State, shared timer, registered outputs and saturating counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur       <= PLL_RST;
      timer     <= '0;
      resetb_q  <= 1'b0;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= '0;
      lost_q    <= '0;
    end else begin
      cur       <= nxt;
      resetb_q  <= (nxt != PLL_RST);
      sys_rst_q <= (nxt != RUN);
      ready_q   <= (nxt == RUN);
      if (bus.relock_req || nxt != cur) timer <= '0;
      else if (cur != RUN) timer <= timer + 1'b1;
      if (inc_fail && fail_q != '1) fail_q <= fail_q + 1'b1;
      if (inc_lost && lost_q != '1) lost_q <= lost_q + 1'b1;
    end
  end

  assign bus.state      = cur;
  assign bus.pll_resetb = resetb_q;
  assign bus.sys_rst    = sys_rst_q;
  assign bus.ready      = ready_q;
  assign bus.fail_cnt   = fail_q;
  assign bus.lost_cnt   = lost_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Randomized bench for pll_rst_seq.
// Reference: phase/elapsed model with a 2-sample lock delay queue.
module tb_pll_rst_seq;

  localparam int P  = 4;
  localparam int T  = 32;
  localparam int S  = 8;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clk;
  logic rst;

  pll_rst_seq_if #(.CNT_W(CW)) bus ();

  pll_rst_seq #(
    .PLL_RST_CYCLES(P),
    .LOCK_TIMEOUT(T),
    .STABLE_CYCLES(S),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  int ph;
  int el;
  int fc;
  int lc;
  int lq[$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("state", int'(bus.state), ph);
    chk("pll_resetb", int'(bus.pll_resetb), (ph != 0) ? 1 : 0);
    chk("sys_rst", int'(bus.sys_rst), (ph != 3) ? 1 : 0);
    chk("ready", int'(bus.ready), (ph == 3) ? 1 : 0);
    chk("fail_cnt", int'(bus.fail_cnt), fc);
    chk("lost_cnt", int'(bus.lost_cnt), lc);
  endtask

  task automatic model_reset();
    ph = 0;
    el = 0;
    fc = 0;
    lc = 0;
    lq = '{0, 0};
  endtask

  // One clock edge of the reference: lock is seen two edges late.
  task automatic model_edge(input logic lk, input logic rq);
    int seen;
    seen = lq.pop_front();
    lq.push_back(int'(lk));
    el++;
    if (rq) begin
      ph = 0;
      el = 0;
    end else if (ph == 0) begin
      if (el == P) begin ph = 1; el = 0; end
    end else if (ph == 1) begin
      if (seen == 1) begin
        ph = 2; el = 0;
      end else if (el == T) begin
        ph = 0; el = 0;
        fc = (fc < CMAX) ? fc + 1 : CMAX;
      end
    end else if (ph == 2) begin
      if (seen == 0) begin ph = 1; el = 0; end
      else if (el == S) begin ph = 3; el = 0; end
    end else begin
      if (seen == 0) begin
        ph = 0; el = 0;
        lc = (lc < CMAX) ? lc + 1 : CMAX;
      end
    end
  endtask

  task automatic step(input logic lk, input logic rq);
    @(negedge clk);
    bus.pll_lock   = lk;
    bus.relock_req = rq;
    @(posedge clk);
    model_edge(lk, rq);
    #1;
    check_all();
  endtask

  task automatic async_rst();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
  endtask

  function automatic logic rnd_req();
    return ($urandom_range(0, 39) == 0);
  endfunction

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    bus.pll_lock   = 1'b0;
    bus.relock_req = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // Lock stuck low: retries and fail_cnt saturation.
    repeat (4 * (P + T) + 4) step(1'b0, 1'b0);
    // Lock arrives, reach RUN, then single-cycle drops.
    for (int k = 0; k < 4; k++) begin
      repeat (P + T) step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      repeat (3) step(1'b1, 1'b0);
    end

    for (int seg = 0; seg < 60; seg++) begin
      int mode;
      int len;
      mode = $urandom_range(0, 5);
      len  = $urandom_range(10, 60);
      case (mode)
        0: repeat (len + T) step(1'b0, rnd_req());
        1: repeat (len) step(1'b1, rnd_req());
        2: begin
          int g;
          g = $urandom_range(2, len);
          for (int i = 0; i < len; i++)
            step((i == g) ? 1'b0 : 1'b1, 1'b0);
        end
        3: repeat (len) step(logic'($urandom_range(0, 1)), rnd_req());
        4: begin
          repeat (P + S + 16) step(1'b1, 1'b0);
          step(1'b0, 1'b0);
          step(1'b0, 1'b0);
          step(1'b0, 1'b1);
          repeat (4) step(1'b0, 1'b0);
        end
        default: begin
          repeat ($urandom_range(P + 3, P + S + 4)) step(1'b1, 1'b0);
          async_rst();
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete, got running, expected done");
    $fatal(1, "timeout");
  end

endmodule
